// File: rtl/seq_match_logger.sv
// seq_match_logger: timestamps 0110 detector matches into a show-ahead FIFO
// with a saturating match count and a sticky overflow flag.
module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             match,
  input  logic             clear,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [TS_W-1:0]  ev_ts,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [TS_W-1:0]  bit_idx_q, bit_idx_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];

  logic ev_evt;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  assign ev_evt = bit_valid & match;
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop    = ~empty & ev_ready;
  // A full FIFO still accepts a push when the head leaves this cycle.
  assign push   = ev_evt & (~full | pop);
  assign drop   = ev_evt & full & ~pop;

  always_comb begin
    bit_idx_d = bit_idx_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    mem_d     = mem_q;
    if (clear) begin
      bit_idx_d = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end else begin
      if (bit_valid) begin
        bit_idx_d = bit_idx_q + TS_W'(1);
      end
      if (push) begin
        mem_d[wptr_q[AW-1:0]] = bit_idx_q;
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (ev_evt && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      bit_idx_q <= bit_idx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
    end
  end

  assign ev_valid = ~empty;
  assign ev_ts    = mem_q[rptr_q[AW-1:0]];
  assign ev_count = cnt_q;
  assign overflow = ovf_q;

endmodule
